// File: rtl/zero_array_manager_if.sv
// Request/response bundle between the Zero array manager and its two requesters.
// The inUse/peakInUse statistics exist only with ARRAY_MANAGER_STATS_EN.
interface zero_array_manager_if #(
    parameter int W = 12
);
    logic [1:0]        reqValid;
    logic [1:0]        reqReady;
    logic [1:0][2:0]   reqOp;
    logic [1:0][W-1:0] reqArray;
    logic [1:0][W-1:0] reqIndex;
    logic [1:0][W-1:0] reqData;
    logic [1:0]        respValid;
    logic [W-1:0]      respData;
    logic              respError;
    logic              busy;
`ifdef ARRAY_MANAGER_STATS_EN
    logic [W-1:0]      inUse;
    logic [W-1:0]      peakInUse;

    modport master (
        output reqValid, reqOp, reqArray, reqIndex, reqData,
        input  reqReady, respValid, respData, respError, busy,
        input  inUse, peakInUse
    );
    modport slave (
        input  reqValid, reqOp, reqArray, reqIndex, reqData,
        output reqReady, respValid, respData, respError, busy,
        output inUse, peakInUse
    );
`else
    modport master (
        output reqValid, reqOp, reqArray, reqIndex, reqData,
        input  reqReady, respValid, respData, respError, busy
    );
    modport slave (
        input  reqValid, reqOp, reqArray, reqIndex, reqData,
        output reqReady, respValid, respData, respError, busy
    );
`endif
endinterface

// File: rtl/zero_array_manager.sv
// Round-robin sequencer for the Zero array heap: size table, freed stack, heap.
// Optional occupancy statistics are enabled by ARRAY_MANAGER_STATS_EN.
module zero_array_manager #(
    parameter int MemoryElementWidth = 12,
    parameter int NArea              = 10,
    parameter int NArrays            = 64
) (
    input  logic clock,
    input  logic reset_n,
    zero_array_manager_if.slave bus
);
    localparam int W     = MemoryElementWidth;
    localparam int DEPTH = NArrays * NArea;
    localparam int AW    = $clog2(DEPTH);
    localparam int IW    = $clog2(NArrays);

    localparam logic [2:0] OP_ALLOC = 3'd0;
    localparam logic [2:0] OP_FREE  = 3'd1;
    localparam logic [2:0] OP_PUSH  = 3'd2;
    localparam logic [2:0] OP_POP   = 3'd3;
    localparam logic [2:0] OP_GET   = 3'd4;
    localparam logic [2:0] OP_SET   = 3'd5;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t       state, state_nx;
    logic         last_q, own_q, gnt, acc;
    logic [2:0]   op_q;
    logic [W-1:0] id_q, idx_q, dat_q;
    logic [W-1:0] sizes [NArrays];
    logic [W-1:0] stack [NArrays];
    logic [W-1:0] heap  [DEPTH];
    logic [W-1:0] sp, allocs, data_q;
    logic         err_q;

    logic [W-1:0]  cur, new_id, off, rd, result, top;
    logic [AW-1:0] addr;
    logic          err, id_ok, wr;

    // Tie goes to the requester not granted last.
    always_comb begin
        gnt = (bus.reqValid == 2'b11) ? ~last_q : bus.reqValid[1];
        bus.reqReady = 2'b00;
        if (state == IDLE && |bus.reqValid && reset_n)
            bus.reqReady = gnt ? 2'b10 : 2'b01;
        acc = |(bus.reqValid & bus.reqReady);
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (acc) state_nx = EXEC;
            EXEC:    state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        cur    = sizes[IW'(id_q)];
        top    = stack[IW'(sp - 1'b1)];
        id_ok  = id_q < allocs;
        new_id = (sp != '0) ? top : allocs;
        err    = 1'b0;
        wr     = 1'b0;
        off    = idx_q;
        result = '0;
        case (op_q)
            OP_ALLOC: begin
                err    = (sp == '0) && (allocs == W'(NArrays));
                result = new_id;
            end
            OP_FREE: err = !id_ok;
            OP_PUSH: begin
                err = !id_ok || cur == W'(NArea);
                off = cur;
                wr  = 1'b1;
            end
            OP_POP: begin
                err = !id_ok || cur == '0;
                off = cur - 1'b1;
            end
            OP_GET: err = !id_ok || idx_q >= cur;
            OP_SET: begin
                err = !id_ok || idx_q >= W'(NArea);
                wr  = 1'b1;
            end
            default: err = 1'b1;
        endcase
        addr = AW'(id_q) * AW'(NArea) + AW'(off);
        rd   = heap[addr];
        if (op_q == OP_POP || op_q == OP_GET) result = rd;
        if (err) result = '0;
    end

    // Heap is deliberately left out of reset.
    always_ff @(posedge clock) begin
        if (state == EXEC && wr && !err) heap[addr] <= dat_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            last_q <= 1'b1;
            own_q  <= 1'b0;
            op_q   <= '0;
            id_q   <= '0;
            idx_q  <= '0;
            dat_q  <= '0;
            sp     <= '0;
            allocs <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
            for (int i = 0; i < NArrays; i++) begin
                sizes[i] <= '0;
                stack[i] <= '0;
            end
        end else begin
            state <= state_nx;
            if (acc) begin
                last_q <= gnt;
                own_q  <= gnt;
                op_q   <= bus.reqOp[gnt];
                id_q   <= bus.reqArray[gnt];
                idx_q  <= bus.reqIndex[gnt];
                dat_q  <= bus.reqData[gnt];
            end
            if (state == EXEC) begin
                data_q <= result;
                err_q  <= err;
                if (!err) begin
                    case (op_q)
                        OP_ALLOC: begin
                            if (sp != '0) sp <= sp - 1'b1;
                            else allocs <= allocs + 1'b1;
                            sizes[IW'(new_id)] <= '0;
                        end
                        OP_FREE: begin
                            stack[IW'(sp)] <= id_q;
                            sp <= sp + 1'b1;
                        end
                        OP_PUSH: sizes[IW'(id_q)] <= cur + 1'b1;
                        OP_POP:  sizes[IW'(id_q)] <= cur - 1'b1;
                        OP_SET:
                            if (idx_q >= cur) sizes[IW'(id_q)] <= idx_q + 1'b1;
                        default: ;
                    endcase
                end
            end
        end
    end

    assign bus.busy      = state != IDLE;
    assign bus.respValid = (state == RESP) ? (own_q ? 2'b10 : 2'b01) : 2'b00;
    assign bus.respData  = data_q;
    assign bus.respError = err_q;

`ifdef ARRAY_MANAGER_STATS_EN
    logic [W-1:0] peak_q;
    logic [W-1:0] in_use;

    assign in_use        = allocs - sp;
    assign bus.inUse     = in_use;
    assign bus.peakInUse = peak_q;

    // Only a successful ALLOC can raise occupancy.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) peak_q <= '0;
        else if (state == EXEC && op_q == OP_ALLOC && !err
                 && in_use + 1'b1 > peak_q)
            peak_q <= in_use + 1'b1;
    end
`endif
endmodule
